fifo: RTL and testbench
=======================

Name: fifo

Overview:
- Single-clock, first-word-fall-through (FWFT) synchronous FIFO with status flags.
- vga_master uses it to queue outstanding SDRAM read addresses (DBITS=26).
- An address is written when a read request is issued.
- The address is popped when the matching read data returns; dout is sampled in that same cycle.
- Generic storage/flag block, no protocol knowledge.

Parameters:
- DBITS, 32, data word width in bits.
- ABITS, 5, log2 of depth; DEPTH = 2**ABITS (32 entries by default).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- wr  input  1  push request; din is captured on this clk edge.
- rd  input  1  pop request; discards the current head on this clk edge.
- din  input  DBITS  write data.
- dout  output  DBITS  current head entry, combinational (FWFT).
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_empty  output  1  count <= 1.
- half_full  output  1  count >= DEPTH/2.
- almost_full  output  1  count >= DEPTH-1.

Behaviour:
- State:
  - wr_ptr and rd_ptr, each ABITS wide, wrapping modulo DEPTH.
  - count, ABITS+1 bits wide, range 0..DEPTH.
  - mem: DEPTH x DBITS, registered writes, no reset on contents.
- Reset: reset is sampled at posedge clk. wr_ptr, rd_ptr and count go to 0. Flags after reset: empty=1, almost_empty=1, full=0, half_full=0, almost_full=0. Reset overrides any simultaneous wr or rd; reset mid-operation discards all entries.
- Flags are decoded combinationally from count only. They change in the cycle after the push/pop edge.
- dout = mem[rd_ptr], combinational, with zero-cycle read latency. It is valid whenever empty=0. When empty=1 its value is don't-care and must not be checked.
- Push accepted when wr=1 and (full=0 or rd=1):
  - mem[wr_ptr] <= din.
  - wr_ptr <= wr_ptr+1.
- Pop accepted when rd=1 and empty=0: rd_ptr <= rd_ptr+1. The value consumed is the dout shown in that cycle.
- count update:
  - +1 on a push alone.
  - -1 on a pop alone.
  - unchanged on simultaneous push and pop.
- Boundary rules:
  - wr while full and rd=0: write dropped; pointers, count and contents unchanged.
  - rd while empty: ignored; no pointer or count change.
  - rd+wr while full: both accepted. The head is popped and din is stored in the freed slot; count stays DEPTH.
  - rd+wr while empty: only the push is accepted; count becomes 1. The new word appears on dout the next cycle, with no same-cycle bypass.
  - Pointer wrap from DEPTH-1 to 0 is seamless; ordering is preserved across wrap.
- No overflow/underflow error outputs; silent drop or ignore as above.
- Latency: a word written at edge N is visible on dout after edge N if it is the new head. Write-to-empty-deassert is 1 cycle.

Decomposition:
- No shared package needed. DEPTH is a localparam derived from ABITS inside the module.
- Single flat module; no sub-module is warranted. Pointer/count logic and the memory array live together.

Test Plan:
- Reset then idle (DBITS=26, ABITS=5) -> empty=1, almost_empty=1, full=0, half_full=0, almost_full=0.
- Push 0x000_0008 then 0x000_0010, no rd -> after edge 1: empty=0, dout=0x08, almost_empty=1. After edge 2: almost_empty=0, dout still 0x08. Pop twice -> dout 0x10, then empty=1.
- Push 32 words 1..32 -> half_full asserts after the 16th push, almost_full after the 31st, full after the 32nd. A 33rd wr (value 99) is dropped. Popping all 32 yields 1..32 in order and never 99.
- Full FIFO with rd=1, wr=1, din=77 -> count stays 32 and full stays 1. Popped value is 1; 77 emerges last after 31 further pops.
- Empty FIFO with rd=1, wr=1, din=5 -> next cycle empty=0, dout=5, count=1. rd on an empty FIFO alone -> no state change.
- Fill 20 words, assert reset for one cycle while wr=1 -> after the edge empty=1, count=0. Subsequent push 0x3FF_FFFF appears on dout (wrap/width check).

Source files
------------

// File: rtl/fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy flags.
// The head entry is presented combinationally on dout; a pop discards it at the edge.
// Flags are decoded from the occupancy count alone, so they settle one cycle after
// the push/pop edge that changes it.
module fifo #(
    parameter int unsigned DBITS = 32,
    parameter int unsigned ABITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic             rd,
    input  logic [DBITS-1:0] din,
    output logic [DBITS-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             almost_empty,
    output logic             half_full,
    output logic             almost_full
);

    localparam int unsigned DEPTH = 2 ** ABITS;

    localparam logic [ABITS:0] CntOne      = (ABITS + 1)'(1);
    localparam logic [ABITS:0] CntHalf     = (ABITS + 1)'(DEPTH / 2);
    localparam logic [ABITS:0] CntAlmFull  = (ABITS + 1)'(DEPTH - 1);
    localparam logic [ABITS:0] CntFull     = (ABITS + 1)'(DEPTH);

    logic [DBITS-1:0] r_mem [DEPTH];
    logic [ABITS-1:0] r_wr_ptr;
    logic [ABITS-1:0] r_rd_ptr;
    logic [ABITS:0]   r_count;

    logic w_push;
    logic w_pop;

    // A push into a full FIFO is allowed only when the head leaves in the same cycle.
    always_comb begin
        w_push = wr && (!full || rd);
        w_pop  = rd && !empty;
    end

    // Storage array: written on an accepted push, contents never reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; reset wins over any push or pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ABITS'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ABITS'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntOne;
                2'b01:   r_count <= r_count - CntOne;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head data and status flags, decoded from the registered state.
    always_comb begin
        dout         = r_mem[r_rd_ptr];
        empty        = (r_count == '0);
        almost_empty = (r_count <= CntOne);
        half_full    = (r_count >= CntHalf);
        almost_full  = (r_count >= CntAlmFull);
        full         = (r_count == CntFull);
    end

endmodule

// File: tb/tb_fifo.sv
// Testbench for fifo (DBITS=26, ABITS=5): directed vector table, corner-case
// sequences, and randomized traffic checked against a queue-based model.
module tb_fifo;

    localparam int unsigned DBITS = 26;
    localparam int unsigned ABITS = 5;
    localparam int          DEPTH = 32;

    logic             clk;
    logic             reset;
    logic             wr;
    logic             rd;
    logic [DBITS-1:0] din;
    logic [DBITS-1:0] dout;
    logic             full;
    logic             empty;
    logic             almost_empty;
    logic             half_full;
    logic             almost_full;

    int n_chk;
    int n_fail;

    logic [DBITS-1:0] mq[$];

    fifo #(
        .DBITS(DBITS),
        .ABITS(ABITS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr          (wr),
        .rd          (rd),
        .din         (din),
        .dout        (dout),
        .full        (full),
        .empty       (empty),
        .almost_empty(almost_empty),
        .half_full   (half_full),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit               w;
        bit               r;
        logic [DBITS-1:0] d;
        bit               e;
        bit               f;
        bit               ae;
        bit               hf;
        bit               af;
        bit               dv;
        logic [DBITS-1:0] dout;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle; the model is advanced from the architectural rules.
    task automatic step(input bit w, input bit r, input bit rs, input logic [DBITS-1:0] d);
        bit push_ok;
        bit pop_ok;
        wr    = w;
        rd    = r;
        reset = rs;
        din   = d;
        if (rs) begin
            mq.delete();
        end else begin
            push_ok = w && ((mq.size() < DEPTH) || r);
            pop_ok  = r && (mq.size() > 0);
            if (pop_ok) void'(mq.pop_front());
            if (push_ok) mq.push_back(d);
        end
        @(posedge clk);
        #1;
        wr    = 1'b0;
        rd    = 1'b0;
        reset = 1'b0;
    endtask

    task automatic check_model(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= 1));
        chk({tag, ".half_full"}, 32'(half_full), 32'(n >= DEPTH / 2));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(n >= DEPTH - 1));
        chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
        if (n > 0) chk({tag, ".dout"}, 32'(dout), 32'(mq[0]));
    endtask

    vec_t vecs[8];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        wr     = 1'b0;
        rd     = 1'b0;
        din    = '0;
        reset  = 1'b1;

        //           w  r  din          e  f  ae hf af dv dout
        vecs[0] = '{1'b0, 1'b0, 26'h0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 26'h0};
        vecs[1] = '{1'b1, 1'b0, 26'h8,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 26'h8};
        vecs[2] = '{1'b1, 1'b0, 26'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 26'h8};
        vecs[3] = '{1'b0, 1'b1, 26'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 26'h10};
        vecs[4] = '{1'b0, 1'b1, 26'h0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 26'h0};
        vecs[5] = '{1'b0, 1'b1, 26'h0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 26'h0};
        vecs[6] = '{1'b1, 1'b1, 26'h5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 26'h5};
        vecs[7] = '{1'b0, 1'b1, 26'h0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 26'h0};

        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b1, '0);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].w, vecs[i].r, 1'b0, vecs[i].d);
            chk($sformatf("vec%0d.empty", i), 32'(empty), 32'(vecs[i].e));
            chk($sformatf("vec%0d.full", i), 32'(full), 32'(vecs[i].f));
            chk($sformatf("vec%0d.almost_empty", i), 32'(almost_empty), 32'(vecs[i].ae));
            chk($sformatf("vec%0d.half_full", i), 32'(half_full), 32'(vecs[i].hf));
            chk($sformatf("vec%0d.almost_full", i), 32'(almost_full), 32'(vecs[i].af));
            if (vecs[i].dv) chk($sformatf("vec%0d.dout", i), 32'(dout), 32'(vecs[i].dout));
        end

        // Fill with 1..32, watching threshold crossings
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, 1'b0, 26'(i));
            chk($sformatf("fill%0d.half_full", i), 32'(half_full), 32'(i >= 16));
            chk($sformatf("fill%0d.almost_full", i), 32'(almost_full), 32'(i >= 31));
            chk($sformatf("fill%0d.full", i), 32'(full), 32'(i == 32));
            chk($sformatf("fill%0d.dout", i), 32'(dout), 32'd1);
        end

        // Write to full without read is dropped
        step(1'b1, 1'b0, 1'b0, 26'd99);
        check_model("drop99");

        // Simultaneous read and write while full
        chk("fullrw.head", 32'(dout), 32'd1);
        step(1'b1, 1'b1, 1'b0, 26'd77);
        chk("fullrw.full", 32'(full), 32'd1);
        chk("fullrw.dout", 32'(dout), 32'd2);

        // Drain: 2..32 then 77, never 99
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain%0d.dout", i), 32'(dout), (i < 31) ? 32'(i + 2) : 32'd77);
            step(1'b0, 1'b1, 1'b0, '0);
        end
        chk("drain.empty", 32'(empty), 32'd1);

        // Fill 20, then reset with a concurrent write
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 26'(100 + i));
        check_model("fill20");
        wr = 1'b1;
        step(1'b1, 1'b0, 1'b1, 26'h123);
        chk("rst.empty", 32'(empty), 32'd1);
        chk("rst.almost_empty", 32'(almost_empty), 32'd1);
        chk("rst.half_full", 32'(half_full), 32'd0);
        step(1'b1, 1'b0, 1'b0, 26'h3FF_FFFF);
        chk("rst.wide_dout", 32'(dout), 32'h3FF_FFFF);
        chk("rst.after_push_empty", 32'(empty), 32'd0);

        // Randomized traffic with varying fill bias and rare resets
        for (int p = 0; p < 4; p++) begin
            int pw;
            int pr;
            pw = (p == 0) ? 80 : (p == 1) ? 30 : (p == 2) ? 55 : 95;
            pr = (p == 0) ? 30 : (p == 1) ? 80 : (p == 2) ? 55 : 60;
            for (int c = 0; c < 500; c++) begin
                bit w;
                bit r;
                bit rs;
                w  = ($urandom_range(99) < pw);
                r  = ($urandom_range(99) < pr);
                rs = ($urandom_range(299) == 0);
                step(w, r, rs, 26'($urandom()));
                check_model($sformatf("rand%0d_%0d", p, c));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
